// File: rtl/counters_pkg.sv
// Shared definitions for the counters library: JK input codes and the
// elaboration-time modulus legality check.
package counters_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 32'sd2) && (longint'(modulus) <= (64'sd1 <<< width));
  endfunction

endpackage

// File: rtl/jk_ff.sv
// JK flip-flop with synchronous active-high reset and registered Q / Qn.
module jk_ff
  import counters_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  logic q_q;
  logic q_bar_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // Qn is kept as its own register so it is a true flop output, not an inverter.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= 1'b0;
      q_bar_q <= 1'b1;
    end else begin
      q_q     <= q_d;
      q_bar_q <= ~q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = q_bar_q;

endmodule

// File: rtl/jk_sync_up_counter.sv
// Mod-MODULUS synchronous up counter built from JK flip-flops, with parallel
// load, count enable and terminal-count / carry outputs for cascading.
module jk_sync_up_counter
  import counters_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             carry
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("jk_sync_up_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] target_s;
  logic             force_s;
  logic             ones_below_s;

  // Reset, load and the terminal wrap all drive J/K straight to a target
  // value; plain counting toggles bit i when every lower bit is one.
  always_comb begin
    force_s = reset | load | (en & tc);
    if (!reset && load && ({1'b0, d} < MOD_W)) begin
      target_s = d;
    end else begin
      target_s = '0;
    end
    ones_below_s = 1'b1;
    j_s = '0;
    k_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (force_s) begin
        j_s[i] = target_s[i];
        k_s[i] = ~target_s[i];
      end else if (en) begin
        j_s[i] = ones_below_s;
        k_s[i] = ones_below_s;
      end else begin
        j_s[i] = 1'b0;
        k_s[i] = 1'b0;
      end
      ones_below_s = ones_below_s & q[i];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j_s[i]),
      .k     (k_s[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  assign tc    = (q == LAST);
  assign carry = tc & en & ~load & ~reset;

endmodule

// File: tb/tb_jk_sync_up_counter.sv
// Directed vector bench driving a mod-16 and a mod-10 instance in lockstep.
module tb_jk_sync_up_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic [3:0] q16, qb16, q10, qb10;
  logic       tc16, c16, tc10, c10;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       reset;
    logic       load;
    logic       en;
    logic [3:0] d;
    logic [3:0] e16;
    logic [3:0] e10;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  jk_sync_up_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
    .q(q16), .q_bar(qb16), .tc(tc16), .carry(c16)
  );

  jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
    .q(q10), .q_bar(qb10), .tc(tc10), .carry(c10)
  );

  task automatic add(input logic r, input logic l, input logic e,
                     input logic [3:0] dv, input logic [3:0] e16v, input logic [3:0] e10v);
    vec_t v;
    v.reset = r; v.load = l; v.en = e; v.d = dv; v.e16 = e16v; v.e10 = e10v;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual=%h expected=%h", name, step, act, exp);
    end
  endtask

  task automatic check_all(input int step, input logic [3:0] e16, input logic [3:0] e10);
    chk("q16", step, q16, e16);
    chk("qbar16", step, qb16, ~e16);
    chk("tc16", step, {3'b000, tc16}, {3'b000, e16 == 4'hF});
    chk("carry16", step, {3'b000, c16}, {3'b000, (e16 == 4'hF) & en & ~load & ~reset});
    chk("q10", step, q10, e10);
    chk("qbar10", step, qb10, ~e10);
    chk("tc10", step, {3'b000, tc10}, {3'b000, e10 == 4'h9});
    chk("carry10", step, {3'b000, c10}, {3'b000, (e10 == 4'h9) & en & ~load & ~reset});
  endtask

  initial begin
    // reset, load, en, d, expected q (mod 16), expected q (mod 10)
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 20; i++) add(1'b0, 1'b0, 1'b1, 4'h0, 4'(i % 16), 4'(i % 10));
    add(1'b0, 1'b1, 1'b1, 4'hC, 4'hC, 4'h0);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'hD, 4'h1);
    add(1'b0, 1'b1, 1'b1, 4'hB, 4'hB, 4'h0);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'hC, 4'h1);
    add(1'b0, 1'b1, 1'b0, 4'h8, 4'h8, 4'h8);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h9, 4'h9);
    add(1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 4'h9);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'hA, 4'h0);
    add(1'b0, 1'b1, 1'b0, 4'h7, 4'h7, 4'h7);
    add(1'b1, 1'b1, 1'b1, 4'h5, 4'h0, 4'h0);
    add(1'b0, 1'b1, 1'b1, 4'h5, 4'h5, 4'h5);
    add(1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h1);

    reset = 1'b1; en = 1'b0; load = 1'b0; d = 4'h0;
    @(posedge clk);
    #1;
    foreach (vecs[n]) begin
      reset = vecs[n].reset;
      load  = vecs[n].load;
      en    = vecs[n].en;
      d     = vecs[n].d;
      @(posedge clk);
      #1;
      check_all(n, vecs[n].e16, vecs[n].e10);
    end

    // Carry must rise combinationally as soon as en is raised at terminal count.
    reset = 1'b0; load = 1'b1; en = 1'b0; d = 4'hF;
    @(posedge clk);
    #1;
    chk("seq_load15", 100, q16, 4'hF);
    load = 1'b0;
    chk("seq_carry_hold", 101, {3'b000, c16}, 4'h0);
    en = 1'b1;
    #1;
    chk("seq_carry_en", 102, {3'b000, c16}, 4'h1);
    chk("seq_tc_en", 103, {3'b000, tc16}, 4'h1);
    @(posedge clk);
    #1;
    chk("seq_wrap16", 104, q16, 4'h0);
    chk("seq_wrap_carry", 105, {3'b000, c16}, 4'h0);
    chk("seq_m10", 106, q10, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
